fifo_stream_reader: RTL and testbench

//   Read-side master for the synchronous FIFO: drains words via rd_en/data_out and presents them
//   on a valid/ready stream to a downstream consumer.

---
 rtl/fifo_stream_reader.sv | 56 +++++
 tb/tb_fifo_stream_reader.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a sync FIFO into a valid/ready stream through a 2-entry buffer; FIFO_READER_STATS_EN adds rd_count
module fifo_stream_reader #(
  parameter int FIFO_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  output logic                  fifo_rd_en,
  input  logic                  flush,
  output logic                  m_valid,
  output logic [FIFO_WIDTH-1:0] m_data,
  input  logic                  m_ready,
  output logic                  underflow_err,
  output logic [CNT_WIDTH-1:0]  rd_count
);
  logic [1:0]            cnt;
  logic                  rd_pending;
  logic [FIFO_WIDTH-1:0] tail;
  logic                  pop;
  logic                  push;
  assign m_valid    = cnt != 2'd0;
  assign pop        = m_valid && m_ready;
  assign push       = rd_pending && !fifo_underflow;
  assign fifo_rd_en = !rst && !flush && !fifo_empty && ((cnt + {1'b0, rd_pending} < 2'd2) || pop);
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt           <= 2'd0;
      rd_pending    <= 1'b0;
      m_data        <= '0;
      tail          <= '0;
      underflow_err <= 1'b0;
    end else begin
      rd_pending <= fifo_rd_en;
      if (rd_pending && fifo_underflow) underflow_err <= 1'b1;
      if (flush) cnt <= 2'd0;
      else begin
        cnt <= cnt + {1'b0, push} - {1'b0, pop};
        // head takes the tail on pop unless the incoming word is the only survivor
        if (pop) m_data <= (cnt == 2'd2 || !push) ? tail : fifo_data_out;
        else if (push && cnt == 2'd0) m_data <= fifo_data_out;
        if (push && (pop ? cnt == 2'd2 : cnt == 2'd1)) tail <= fifo_data_out;
      end
    end
  end
`ifdef FIFO_READER_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) rd_count <= '0;
    else if (pop && !flush && rd_count != '1) rd_count <= rd_count + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  end
`else
  assign rd_count = '0;
`endif
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: directed bench for fifo_stream_reader against a behavioural FIFO
module tb_fifo_stream_reader;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] fifo_data_out = '0;
  logic        fifo_empty;
  logic        fifo_underflow;
  logic        fifo_rd_en;
  logic        flush = 1'b0;
  logic        m_valid;
  logic [15:0] m_data;
  logic        m_ready = 1'b0;
  logic        underflow_err;
  logic [15:0] rd_count;
  logic        force_uf = 1'b0;
  logic [15:0] mem [0:63];
  int          rp = 0;
  int          wp = 0;
  int          checks = 0;
  int          failures = 0;
  int          exp_pops = 0;
`ifdef FIFO_READER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  fifo_stream_reader #(.FIFO_WIDTH(16), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .fifo_data_out(fifo_data_out), .fifo_empty(fifo_empty),
    .fifo_underflow(fifo_underflow), .fifo_rd_en(fifo_rd_en), .flush(flush),
    .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
    .underflow_err(underflow_err), .rd_count(rd_count)
  );

  always #5 clk = ~clk;
  assign fifo_empty     = (rp == wp);
  assign fifo_underflow = force_uf;

  always @(posedge clk) begin
    if (fifo_rd_en && rp != wp) begin
      fifo_data_out <= mem[rp];
      rp <= rp + 1;
    end
  end

  always @(negedge clk) begin
    if (!rst && !flush && m_valid && m_ready) exp_pops++;
  end

  task automatic load(input logic [15:0] v);
    mem[wp] = v;
    wp++;
  endtask

  task automatic test_reset();
    load(16'h0011); load(16'h0022); load(16'h0033);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if (fifo_rd_en !== 1'b0 || m_valid !== 1'b0 || underflow_err !== 1'b0 || rd_count !== 16'd0 || m_data !== 16'd0) begin
        failures++;
        $display("FAIL reset: rd_en=%b m_valid=%b uerr=%b rd_count=%0d m_data=%h, required 0 0 0 0 0000", fifo_rd_en, m_valid, underflow_err, rd_count, m_data);
      end
    end
    @(posedge clk); #1;
    wp = rp;
  endtask

  task automatic test_streaming();
    int first = -1, last = -1, nrd = 0, idx = 0;
    for (int i = 1; i <= 8; i++) load(16'(i));
    m_ready = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (fifo_rd_en) nrd++;
      if (m_valid && first < 0) first = c;
      if (m_valid && m_ready) begin
        checks++;
        if (m_data !== 16'(idx + 1)) begin
          failures++;
          $display("FAIL stream_data: got %h, required %h", m_data, 16'(idx + 1));
        end
        idx++;
        last = c;
      end
    end
    checks++;
    if (first != 2) begin failures++; $display("FAIL stream_latency: m_valid at cycle %0d, required 2", first); end
    checks++;
    if (idx != 8 || last != 9) begin failures++; $display("FAIL stream_count: pops=%0d last=%0d, required 8 and 9", idx, last); end
    checks++;
    if (nrd != 8) begin failures++; $display("FAIL stream_rd_en: high %0d cycles, required 8", nrd); end
  endtask

  task automatic test_backpressure();
    int nrd = 0, idx = 0;
    bit held = 1'b1;
    @(posedge clk); #1 m_ready = 1'b0;
    for (int i = 1; i <= 4; i++) load(16'(i));
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (fifo_rd_en) nrd++;
      if (c >= 2 && (m_valid !== 1'b1 || m_data !== 16'h0001)) held = 1'b0;
    end
    checks++;
    if (nrd != 2) begin failures++; $display("FAIL bp_reads: %0d reads, required 2", nrd); end
    checks++;
    if (!held) begin failures++; $display("FAIL bp_hold: m_valid=%b m_data=%h, required 1 0001 held", m_valid, m_data); end
    @(posedge clk); #1 m_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (m_valid && m_ready) begin
        checks++;
        if (m_data !== 16'(idx + 1)) begin failures++; $display("FAIL bp_order: got %h, required %h", m_data, 16'(idx + 1)); end
        idx++;
      end
    end
    checks++;
    if (idx != 4) begin failures++; $display("FAIL bp_count: %0d pops, required 4", idx); end
  endtask

  task automatic test_simultaneous();
    @(posedge clk); #1 m_ready = 1'b0;
    load(16'h00A1); load(16'h00A2); load(16'h00AA);
    repeat (4) @(negedge clk);
    checks++;
    if (m_valid !== 1'b1 || m_data !== 16'h00A1 || fifo_rd_en !== 1'b0) begin
      failures++;
      $display("FAIL sim_full: m_valid=%b m_data=%h rd_en=%b, required 1 00a1 0", m_valid, m_data, fifo_rd_en);
    end
    #1 m_ready = 1'b1;
    #1;
    checks++;
    if (fifo_rd_en !== 1'b1) begin failures++; $display("FAIL sim_rd_on_pop: rd_en=%b, required 1", fifo_rd_en); end
    @(posedge clk); #1 m_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b1 || m_data !== 16'h00A2) begin failures++; $display("FAIL sim_head: m_valid=%b m_data=%h, required 1 00a2", m_valid, m_data); end
    @(posedge clk); #1 m_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (m_data !== 16'h00A2) begin failures++; $display("FAIL sim_pop1: got %h, required 00a2", m_data); end
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b1 || m_data !== 16'h00AA) begin failures++; $display("FAIL sim_tail: m_valid=%b m_data=%h, required 1 00aa", m_valid, m_data); end
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0) begin failures++; $display("FAIL sim_drain: m_valid=%b, required 0", m_valid); end
  endtask

  task automatic test_flush();
    int idx = 0;
    logic [15:0] exp_w [0:1];
    exp_w[0] = 16'h00B3;
    exp_w[1] = 16'h00B4;
    @(posedge clk); #1 m_ready = 1'b0;
    load(16'h00B1); load(16'h00B2); load(16'h00B3); load(16'h00B4);
    repeat (2) @(posedge clk);
    #1 flush = 1'b1; m_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (fifo_rd_en !== 1'b0) begin failures++; $display("FAIL flush_rd_en: rd_en=%b, required 0", fifo_rd_en); end
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0 || fifo_rd_en !== 1'b1) begin
      failures++;
      $display("FAIL flush_after: m_valid=%b rd_en=%b, required 0 1", m_valid, fifo_rd_en);
    end
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (m_valid && m_ready) begin
        checks++;
        if (idx > 1 || m_data !== exp_w[idx[0]]) begin failures++; $display("FAIL flush_data: pop %0d got %h, required b3 then b4", idx, m_data); end
        idx++;
      end
    end
    checks++;
    if (idx != 2) begin failures++; $display("FAIL flush_count: %0d pops, required 2", idx); end
  endtask

  task automatic test_underflow();
    @(posedge clk); #1 m_ready = 1'b0; force_uf = 1'b1;
    @(posedge clk); #1 force_uf = 1'b0;
    @(negedge clk);
    checks++;
    if (underflow_err !== 1'b0) begin failures++; $display("FAIL uf_ignored: uerr=%b, required 0", underflow_err); end
    @(posedge clk); #1 load(16'h00C1);
    @(posedge clk); #1 force_uf = 1'b1;
    @(posedge clk); #1 force_uf = 1'b0;
    @(negedge clk);
    checks++;
    if (underflow_err !== 1'b1 || m_valid !== 1'b0) begin
      failures++;
      $display("FAIL uf_set: uerr=%b m_valid=%b, required 1 0", underflow_err, m_valid);
    end
    @(posedge clk); #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (underflow_err !== 1'b1 || m_valid !== 1'b0) begin
      failures++;
      $display("FAIL uf_sticky: uerr=%b m_valid=%b, required 1 0", underflow_err, m_valid);
    end
  endtask

  task automatic test_stats();
    logic [15:0] exp_c;
    @(negedge clk);
    exp_c = STATS ? 16'(exp_pops) : 16'd0;
    checks++;
    if (rd_count !== exp_c) begin failures++; $display("FAIL stats_total: rd_count=%0d, required %0d", rd_count, exp_c); end
    @(posedge clk); #1 rst = 1'b1; m_ready = 1'b1;
    for (int i = 1; i <= 5; i++) load(16'(16'h00D0 + i));
    repeat (2) @(negedge clk);
    checks++;
    if (rd_count !== 16'd0 || underflow_err !== 1'b0) begin
      failures++;
      $display("FAIL stats_reset: rd_count=%0d uerr=%b, required 0 0", rd_count, underflow_err);
    end
    @(posedge clk); #1 rst = 1'b0;
    repeat (12) @(negedge clk);
    exp_c = STATS ? 16'd5 : 16'd0;
    checks++;
    if (rd_count !== exp_c || m_valid !== 1'b0) begin
      failures++;
      $display("FAIL stats_five: rd_count=%0d m_valid=%b, required %0d 0", rd_count, m_valid, exp_c);
    end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_simultaneous();
    test_flush();
    test_underflow();
    test_stats();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
